// File: rtl/pinwheel_lsu_pkg.sv
// Shared types and helpers for the pinwheel load/store unit.
package pinwheel_lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_HI   = 2'd1,
        LD_LAST = 2'd2,
        ST_HI   = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // Size 3 falls through to a full word.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  return 4'h1;
            SIZE_H:  return 4'h3;
            default: return 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/pinwheel_lsu_align.sv
// Byte-lane steering: store rotate, 8-bit split mask, and load extract/extend.
module pinwheel_lsu_align
    import pinwheel_lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [63:0] pair,
    input  logic [31:0] wdata,
    output logic [31:0] load_c,
    output logic [31:0] wdata_c,
    output logic [7:0]  m8_c
);

    logic [31:0] shifted_c;

    always_comb begin
        m8_c = 8'({4'b0000, size_mask(size)} << off);
        case (off)
            2'd0:    wdata_c = wdata;
            2'd1:    wdata_c = {wdata[23:0], wdata[31:24]};
            2'd2:    wdata_c = {wdata[15:0], wdata[31:16]};
            default: wdata_c = {wdata[7:0],  wdata[31:8]};
        endcase
    end

    // {hi,lo} shifted down to the addressed byte, then truncated and extended.
    always_comb begin
        shifted_c = 32'(pair >> {off, 3'b000});
        case (size)
            SIZE_B:  load_c = sgn ? {{24{shifted_c[7]}}, shifted_c[7:0]}
                                  : {24'b0, shifted_c[7:0]};
            SIZE_H:  load_c = sgn ? {{16{shifted_c[15]}}, shifted_c[15:0]}
                                  : {16'b0, shifted_c[15:0]};
            default: load_c = shifted_c;
        endcase
    end

endmodule

// File: rtl/pinwheel_lsu.sv
// Load/store unit in front of pinwheel_mem; splits misaligned accesses into
// two word accesses and returns extended load data.
module pinwheel_lsu
    import pinwheel_lsu_pkg::*;
#(
    parameter  int unsigned DEPTH     = 256,
    localparam int unsigned ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 mem_cs,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_wren,
    output logic [3:0]           mem_mask,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata
);

    lsu_state_t            state;
    lsu_state_t            state_nxt;
    lsu_req_t              cap;
    lsu_req_t              live_c;
    lsu_req_t              cur_c;
    logic [31:0]           lo_buf;
    logic [ADDR_BITS-1:0]  word_c;
    logic [7:0]            m8_c;
    logic [31:0]           wrot_c;
    logic [31:0]           load_c;
    logic [63:0]           pair_c;
    logic                  misaligned_c;
    logic                  accept_c;
    logic                  unused_addr_c;

    // In IDLE the live request steers memory; afterwards the captured copy does.
    always_comb begin
        live_c       = '{write: req_write, size: req_size, sgn: req_signed,
                         addr: req_addr, wdata: req_wdata};
        cur_c        = (state == IDLE) ? live_c : cap;
        word_c       = cur_c.addr[ADDR_BITS+1:2];
        misaligned_c = (m8_c[7:4] != 4'h0);
        accept_c     = (state == IDLE) && req_valid;
        pair_c       = misaligned_c ? {mem_rdata, lo_buf} : {32'b0, mem_rdata};
    end

    assign unused_addr_c = ^cur_c.addr[31:ADDR_BITS+2];

    pinwheel_lsu_align u_align (
        .off     (cur_c.addr[1:0]),
        .size    (cur_c.size),
        .sgn     (cur_c.sgn),
        .pair    (pair_c),
        .wdata   (cur_c.wdata),
        .load_c  (load_c),
        .wdata_c (wrot_c),
        .m8_c    (m8_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_write) begin
                        state_nxt = misaligned_c ? ST_HI : IDLE;
                    end else begin
                        state_nxt = misaligned_c ? LD_HI : LD_LAST;
                    end
                end
            end
            LD_HI:   state_nxt = LD_LAST;
            LD_LAST: state_nxt = IDLE;
            ST_HI:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory port: low access from IDLE, high access (wrapping word) from *_HI.
    always_comb begin
        req_ready = 1'b0;
        mem_cs    = 1'b0;
        mem_wren  = 1'b0;
        mem_mask  = 4'h0;
        mem_addr  = word_c;
        mem_wdata = wrot_c;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                mem_cs    = req_valid;
                mem_wren  = req_valid && req_write;
                mem_mask  = req_valid ? m8_c[3:0] : 4'h0;
            end
            LD_HI: begin
                mem_cs   = 1'b1;
                mem_addr = word_c + ADDR_BITS'(1);
                mem_mask = m8_c[7:4];
            end
            ST_HI: begin
                mem_cs   = 1'b1;
                mem_wren = 1'b1;
                mem_addr = word_c + ADDR_BITS'(1);
                mem_mask = m8_c[7:4];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap        <= '0;
            lo_buf     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            if (accept_c) begin
                cap <= live_c;
            end
            if (state == LD_HI) begin
                lo_buf <= mem_rdata;
            end
            resp_valid <= (accept_c && req_write && !misaligned_c)
                       || (state == ST_HI) || (state == LD_LAST);
            resp_rdata <= (state == LD_LAST) ? load_c : '0;
        end
    end

endmodule

// File: tb/tb_pinwheel_lsu.sv
// Directed self-checking bench for pinwheel_lsu with a behavioural pinwheel_mem.
module tb_pinwheel_lsu;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_cs;
    logic [7:0]  mem_addr;
    logic        mem_wren;
    logic [3:0]  mem_mask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];

    int total;
    int bad;

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  addr0;
        logic [3:0]  mask0;
        logic [31:0] wdata0;
        logic        split;
        logic [7:0]  addr1;
        logic [3:0]  mask1;
        int          lat;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [0:NV-1];
    logic [31:0] bb [0:3];

    pinwheel_lsu #(.DEPTH(256)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_cs     (mem_cs),
        .mem_addr   (mem_addr),
        .mem_wren   (mem_wren),
        .mem_mask   (mem_mask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clock = ~clock;

    // pinwheel_mem model: byte-masked write, registered read on cs && !wren.
    always @(posedge clock) begin
        if (mem_cs) begin
            if (mem_wren) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_mask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        lat = 0;
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = v.write;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        #1;
        check("ready", 32'(req_ready), 32'd1);
        check("cs0", 32'(mem_cs), 32'd1);
        check("addr0", 32'(mem_addr), 32'(v.addr0));
        check("mask0", 32'(mem_mask), 32'(v.mask0));
        check("wren0", 32'(mem_wren), 32'(v.write));
        if (v.write) check("wdata0", mem_wdata, v.wdata0);
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        check("cs1", 32'(mem_cs), 32'(v.split));
        if (v.split) begin
            check("addr1", 32'(mem_addr), 32'(v.addr1));
            check("mask1", 32'(mem_mask), 32'(v.mask1));
            check("wren1", 32'(mem_wren), 32'(v.write));
        end
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) begin
                @(negedge clock);
                #1;
            end
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", 32'(lat), 32'(v.lat));
        if (lat != 0) check("rdata", resp_rdata, v.rdata);
    endtask

    initial begin
        logic seen;
        vec_t rv;
        total = 0;
        bad   = 0;
        clock = 1'b0;
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        //          wr size sg addr       wdata         a0   m0    wdata0        sp a1  m1   lat rdata
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'h11223344, 8'd4,   4'hF, 32'h11223344, 1'b0, 8'd0, 4'h0, 1, 32'h0};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        8'd4,   4'hF, 32'h0,        1'b0, 8'd0, 4'h0, 2, 32'h11223344};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h13,  32'hAB,       8'd4,   4'h8, 32'hAB000000, 1'b0, 8'd0, 4'h0, 1, 32'h0};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        8'd4,   4'h8, 32'h0,        1'b0, 8'd0, 4'h0, 2, 32'hFFFFFFAB};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        8'd4,   4'h8, 32'h0,        1'b0, 8'd0, 4'h0, 2, 32'h000000AB};
        vecs[5]  = '{1'b1, 2'd0, 1'b0, 32'h20,  32'h5A,       8'd8,   4'h1, 32'h0000005A, 1'b0, 8'd0, 4'h0, 1, 32'h0};
        vecs[6]  = '{1'b1, 2'd2, 1'b0, 32'h21,  32'hDEADBEEF, 8'd8,   4'hE, 32'hADBEEFDE, 1'b1, 8'd9, 4'h1, 2, 32'h0};
        vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h21,  32'h0,        8'd8,   4'hE, 32'h0,        1'b1, 8'd9, 4'h1, 3, 32'hDEADBEEF};
        vecs[8]  = '{1'b0, 2'd0, 1'b0, 32'h20,  32'h0,        8'd8,   4'h1, 32'h0,        1'b0, 8'd0, 4'h0, 2, 32'h0000005A};
        vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h3FF, 32'h8001,     8'd255, 4'h8, 32'h01000080, 1'b1, 8'd0, 4'h1, 2, 32'h0};
        vecs[10] = '{1'b0, 2'd1, 1'b1, 32'h3FF, 32'h0,        8'd255, 4'h8, 32'h0,        1'b1, 8'd0, 4'h1, 3, 32'hFFFF8001};
        vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h3FF, 32'h0,        8'd255, 4'h8, 32'h0,        1'b1, 8'd0, 4'h1, 3, 32'h00008001};
        vecs[12] = '{1'b0, 2'd1, 1'b1, 32'h12,  32'h0,        8'd4,   4'hC, 32'h0,        1'b0, 8'd0, 4'h0, 2, 32'hFFFFAB22};
        vecs[13] = '{1'b0, 2'd3, 1'b0, 32'h13,  32'h0,        8'd4,   4'h8, 32'h0,        1'b1, 8'd5, 4'h7, 3, 32'h000000AB};
        vecs[14] = '{1'b1, 2'd1, 1'b0, 32'h01,  32'h1234,     8'd0,   4'h6, 32'h00123400, 1'b0, 8'd0, 4'h0, 1, 32'h0};
        vecs[15] = '{1'b0, 2'd1, 1'b0, 32'h01,  32'h0,        8'd0,   4'h6, 32'h0,        1'b0, 8'd0, 4'h0, 2, 32'h00001234};

        // Reset state
        @(negedge clock);
        @(negedge clock);
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_cs", 32'(mem_cs), 32'd0);
        check("rst_wren", 32'(mem_wren), 32'd0);
        check("rst_mask", 32'(mem_mask), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // Reset asserted while in LD_HI
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h21; req_wdata = '0;
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        check("ldhi_cs", 32'(mem_cs), 32'd1);
        check("ldhi_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_cs", 32'(mem_cs), 32'd0);
        check("midrst_resp", 32'(resp_valid), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clock);
            #1;
            seen = seen | resp_valid;
        end
        check("midrst_no_resp", 32'(seen), 32'd0);

        // Back-to-back aligned word stores
        bb[0] = 32'hA0A1A2A3; bb[1] = 32'hB0B1B2B3; bb[2] = 32'hC0C1C2C3; bb[3] = 32'hD0D1D2D3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
            req_addr = 32'(i * 4); req_wdata = bb[i];
            #1;
            check("bb_ready", 32'(req_ready), 32'd1);
            check("bb_resp", 32'(resp_valid), 32'(i > 0));
        end
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        check("bb_resp_last", 32'(resp_valid), 32'd1);
        @(negedge clock);
        #1;
        check("bb_resp_done", 32'(resp_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rv = '{1'b0, 2'd2, 1'b0, 32'(i * 4), 32'h0, 8'(i), 4'hF, 32'h0,
                   1'b0, 8'd0, 4'h0, 2, bb[i]};
            run_vec(rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
